// File: rtl/vsync_sequencer.sv
// vsync_sequencer: raster h/v counters that address the vertical-timing PROM and decode its flags.
// Define VSEQ_IRQ_EN to build the vertical interrupt (prom_d[0] rising across lines); otherwise irq=0.
module vsync_sequencer #(
  parameter int H_TOTAL       = 384,
  parameter int H_BLANK_START = 256,
  parameter int H_SYNC_START  = 288,
  parameter int H_SYNC_END    = 320,
  parameter int PROM_LAT      = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ce,
  output logic [7:0] prom_a,
  output logic       prom_e,
  input  logic [3:0] prom_d,
  output logic [8:0] hcount,
  output logic [7:0] vcount,
  output logic       hblank,
  output logic       hsync,
  output logic       vblank,
  output logic       vsync,
  output logic       frame_start,
  output logic       irq,
  input  logic       irq_ack
);

  localparam logic [8:0] H_LAST  = 9'(H_TOTAL - 1);
  localparam logic [8:0] H_BLANK = 9'(H_BLANK_START);
  localparam logic [8:0] H_SYNC0 = 9'(H_SYNC_START);
  localparam logic [8:0] H_SYNC1 = 9'(H_SYNC_END);
  localparam logic [8:0] H_CAPT  = 9'(PROM_LAT);

  logic [8:0] hcount_nxt;
  logic       line_end;
  logic       capture;

  assign line_end   = (hcount == H_LAST);
  assign hcount_nxt = line_end ? 9'd0 : hcount + 9'd1;
  assign capture    = ce && (hcount == H_CAPT);
  assign prom_a     = vcount;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prom_e <= 1'b0;
    end else begin
      prom_e <= 1'b1;
    end
  end

  // hblank/hsync decode the next count so they line up with the hcount they describe
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hcount <= 9'd0;
      vcount <= 8'd0;
      hblank <= 1'b0;
      hsync  <= 1'b0;
    end else if (ce) begin
      hcount <= hcount_nxt;
      hblank <= (hcount_nxt >= H_BLANK);
      hsync  <= (hcount_nxt >= H_SYNC0) && (hcount_nxt < H_SYNC1);
      if (line_end) begin
        vcount <= vcount + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= ce && line_end && (vcount == 8'hff);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vblank <= 1'b0;
      vsync  <= 1'b0;
    end else if (capture) begin
      vblank <= prom_d[2];
      vsync  <= prom_d[1];
    end
  end

`ifdef VSEQ_IRQ_EN
  logic bit0_hist;
  logic irq_set;

  assign irq_set = capture && prom_d[0] && !bit0_hist;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit0_hist <= 1'b0;
    end else if (capture) begin
      bit0_hist <= prom_d[0];
    end
  end

  // a new edge outranks an acknowledge arriving on the same clock
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq <= 1'b0;
    end else if (irq_set) begin
      irq <= 1'b1;
    end else if (irq_ack) begin
      irq <= 1'b0;
    end
  end

  logic unused_bits;
  assign unused_bits = prom_d[3];
`else
  assign irq = 1'b0;

  logic unused_bits;
  assign unused_bits = ^{prom_d[3], prom_d[0], irq_ack};
`endif

endmodule

// File: tb/tb_vsync_sequencer.sv
// Directed bench for vsync_sequencer with a short line length so whole frames fit in the run.
// PROM model: registered read of a vertical image (blank 0xdc..0xfe, sync 0xe7..0xf2, bit0 on 0x5e,0x5f,0xa0).
module tb_vsync_sequencer;

  localparam int HT  = 48;
  localparam int HB  = 32;
  localparam int HS0 = 36;
  localparam int HS1 = 40;
  localparam int LAT = 2;
`ifdef VSEQ_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic       clk;
  logic       reset_n;
  logic       ce;
  logic [7:0] prom_a;
  logic       prom_e;
  logic [3:0] prom_d;
  logic [8:0] hcount;
  logic [7:0] vcount;
  logic       hblank, hsync, vblank, vsync, frame_start, irq;
  logic       irq_ack;

  int total = 0;
  int bad   = 0;

  vsync_sequencer #(
    .H_TOTAL(HT), .H_BLANK_START(HB), .H_SYNC_START(HS0), .H_SYNC_END(HS1), .PROM_LAT(LAT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .ce(ce),
    .prom_a(prom_a), .prom_e(prom_e), .prom_d(prom_d),
    .hcount(hcount), .vcount(vcount),
    .hblank(hblank), .hsync(hsync), .vblank(vblank), .vsync(vsync),
    .frame_start(frame_start), .irq(irq), .irq_ack(irq_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] img(input logic [7:0] a);
    logic [3:0] d;
    d = 4'd0;
    d[3] = a[0];
    if (a >= 8'hdc && a <= 8'hfe) d[2] = 1'b1;
    if (a >= 8'he7 && a <= 8'hf2) d[1] = 1'b1;
    if (a == 8'h5e || a == 8'h5f || a == 8'ha0) d[0] = 1'b1;
    return d;
  endfunction

  initial prom_d = 4'd0;
  always @(posedge clk) if (prom_e) prom_d <= img(prom_a);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_at(input logic [7:0] v, input logic [8:0] h);
    int n;
    n = 0;
    while (!(vcount == v && hcount == h) && n < 13000) begin
      tick();
      n++;
    end
    total++;
    assert (vcount == v && hcount == h) else begin
      bad++;
      $error("FAIL wait_%0h_%0h: stopped at v=%0h h=%0h", v, h, vcount, hcount);
    end
  endtask

  initial begin
    int n;
    int ce_err;
    logic [8:0] exp_h;

    reset_n = 1'b0;
    ce      = 1'b1;
    irq_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hcount", hcount, 0);
    chk("rst_vcount", vcount, 0);
    chk("rst_prom_a", prom_a, 0);
    chk("rst_prom_e", prom_e, 0);
    chk("rst_hblank", hblank, 0);
    chk("rst_hsync", hsync, 0);
    chk("rst_vblank", vblank, 0);
    chk("rst_vsync", vsync, 0);
    chk("rst_fs", frame_start, 0);
    chk("rst_irq", irq, 0);

    @(negedge clk);
    reset_n = 1'b1;
    tick();
    chk("rel_prom_e", prom_e, 1);
    chk("rel_hcount", hcount, 1);
    n = 1;
    while (hcount != 9'(HT - 1) && n < 100) begin
      tick();
      n++;
    end
    chk("line_len", n, HT - 1);
    tick();
    chk("line1_hcount", hcount, 0);
    chk("line1_vcount", vcount, 1);
    chk("line1_prom_a", prom_a, 1);

    wait_at(8'h5e, 9'd1);
    chk("irq_pre", irq, 0);
    tick();
    tick();
    chk("irq_set", irq, IRQ_ON);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    chk("irq_ack", irq, 0);
    wait_at(8'h5f, 9'd3);
    chk("irq_no_refire", irq, 0);

    wait_at(8'ha0, 9'd1);
    irq_ack = 1'b1;
    tick();
    tick();
    chk("irq_set_wins", irq, IRQ_ON);
    tick();
    chk("irq_ack_held", irq, 0);
    irq_ack = 1'b0;

    wait_at(8'hdb, 9'd40);
    ce_err = 0;
    exp_h = 9'd40;
    for (int g = 0; g < 11; g++) begin
      exp_h = (exp_h == 9'(HT - 1)) ? 9'd0 : exp_h + 9'd1;
      ce = 1'b1;
      tick();
      ce = 1'b0;
      if (hcount !== exp_h) ce_err++;
      for (int k = 0; k < 3; k++) begin
        tick();
        if (hcount !== exp_h) ce_err++;
      end
      if (g == 8) chk("gated_vblank_h1", vblank, 0);
    end
    ce = 1'b1;
    chk("gated_steps", ce_err, 0);
    chk("gated_vcount", vcount, 8'hdc);
    chk("gated_hcount", hcount, 3);
    chk("gated_vblank_h3", vblank, 1);

    wait_at(8'he6, 9'd3);
    chk("vsync_e6", vsync, 0);
    wait_at(8'he7, 9'd3);
    chk("vsync_e7", vsync, 1);
    wait_at(8'hf2, 9'd3);
    chk("vsync_f2", vsync, 1);
    wait_at(8'hf3, 9'd3);
    chk("vsync_f3", vsync, 0);
    wait_at(8'hff, 9'd1);
    chk("vblank_ff_h1", vblank, 1);
    tick();
    tick();
    chk("vblank_ff_h3", vblank, 0);

    wait_at(8'hff, 9'(HT - 1));
    chk("fs_before", frame_start, 0);
    tick();
    chk("wrap_vcount", vcount, 0);
    chk("wrap_prom_a", prom_a, 0);
    chk("fs_pulse", frame_start, 1);
    tick();
    chk("fs_after", frame_start, 0);

    wait_at(8'h01, 9'd0);
    for (int i = 0; i < HT; i++) begin
      chk($sformatf("hblank_%0d", i), hblank, (i >= HB));
      chk($sformatf("hsync_%0d", i), hsync, (i >= HS0 && i < HS1));
      tick();
    end

    wait_at(8'he8, 9'd20);
    chk("pre_async_vsync", vsync, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_hcount", hcount, 0);
    chk("async_vcount", vcount, 0);
    chk("async_prom_e", prom_e, 0);
    chk("async_vsync", vsync, 0);
    chk("async_vblank", vblank, 0);
    @(negedge clk);
    reset_n = 1'b1;
    wait_at(8'h00, 9'd3);
    chk("restart_vsync", vsync, 0);
    chk("restart_vblank", vblank, 0);
    chk("restart_prom_e", prom_e, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
